// File: rtl/fetch_sequencer_if.sv
// Memory read port and downstream instruction handshake of the fetch sequencer.
// The master modport is the sequencer side; the slave modport is the memory/decode side.
interface fetch_sequencer_if;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [2:0]  inst_fmt;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output mem_addr, mem_read, mem_write, mem_wdata,
      input  mem_rdata,
      output inst_valid, inst, inst_pc, inst_fmt,
      input  inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_read, mem_write, mem_wdata,
      output mem_rdata,
      input  inst_valid, inst, inst_pc, inst_fmt,
      output inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads instruction memory, classifies each
// word by RISC-V format and hands it downstream, following JAL targets and redirects.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0028,
   parameter int unsigned MEM_LAT         = 1,
   parameter logic [31:0] MAX_FETCH       = 32'd0,
   parameter bit          FOLLOW_JAL      = 1'b1,
   parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   fetch_sequencer_if.master  bus,
   output logic               halted,
   output logic [31:0]        fetch_count
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StHold,
      StHalt
   } state_e;

   localparam logic [31:0] StartPc = {RESET_PC[31:2], 2'b00};
   localparam logic [2:0]  LatLoad = 3'(MEM_LAT);

   localparam logic [2:0] FmtUnknown = 3'd0;
   localparam logic [2:0] FmtR       = 3'd1;
   localparam logic [2:0] FmtI       = 3'd2;
   localparam logic [2:0] FmtS       = 3'd3;
   localparam logic [2:0] FmtSB      = 3'd4;
   localparam logic [2:0] FmtUJ      = 3'd5;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  lat_q, lat_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instPc_q, instPc_d;
   logic [2:0]  fmt_q, fmt_d;
   logic [31:0] count_q, count_d;

   logic [20:0] jalOffset;
   logic [31:0] jalTarget;
   logic [31:0] computedNext;
   logic [31:0] redirAligned;
   logic [31:0] countInc;
   logic        haltNow;

   function automatic logic [2:0] decodeFmt(input logic [6:0] opcode);
      logic [2:0] fmt;
      case (opcode)
         7'h33:        fmt = FmtR;
         7'h03, 7'h13: fmt = FmtI;
         7'h23:        fmt = FmtS;
         7'h63:        fmt = FmtSB;
         7'h6F:        fmt = FmtUJ;
         default:      fmt = FmtUnknown;
      endcase
      return fmt;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pc_q     <= StartPc;
         lat_q    <= 3'd0;
         inst_q   <= 32'd0;
         instPc_q <= 32'd0;
         fmt_q    <= FmtUnknown;
         count_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         lat_q    <= lat_d;
         inst_q   <= inst_d;
         instPc_q <= instPc_d;
         fmt_q    <= fmt_d;
         count_q  <= count_d;
      end
   end

   // JAL offset is scattered across the word; the target may be only halfword aligned, so it is forced to a word.
   assign jalOffset    = {inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
   assign jalTarget    = instPc_q + {{11{jalOffset[20]}}, jalOffset};
   assign computedNext = ((FOLLOW_JAL && (fmt_q == FmtUJ)) ? jalTarget : (pc_q + 32'd4)) & ~32'h3;
   assign redirAligned = bus.redirect_pc & ~32'h3;
   assign countInc     = count_q + 32'd1;
   assign haltNow      = ((MAX_FETCH != 32'd0) && (countInc == MAX_FETCH)) ||
                         (HALT_ON_ILLEGAL && (fmt_q == FmtUnknown));

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      lat_d    = lat_q;
      inst_d   = inst_q;
      instPc_d = instPc_q;
      fmt_d    = fmt_q;
      count_d  = count_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               pc_d    = StartPc;
            end
         end
         StFetch: begin
            if (bus.redirect) begin
               pc_d = redirAligned;
            end else begin
               state_d = StWait;
               lat_d   = LatLoad;
            end
         end
         StWait: begin
            if (bus.redirect) begin
               state_d = StFetch;
               pc_d    = redirAligned;
            end else if (lat_q <= 3'd1) begin
               state_d  = StHold;
               inst_d   = bus.mem_rdata;
               instPc_d = pc_q;
               fmt_d    = decodeFmt(bus.mem_rdata[6:0]);
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         StHold: begin
            // A completed handshake always counts; halting wins over a simultaneous redirect.
            if (bus.inst_ready) begin
               count_d = countInc;
               if (haltNow) begin
                  state_d = StHalt;
               end else begin
                  state_d = StFetch;
                  pc_d    = bus.redirect ? redirAligned : computedNext;
               end
            end else if (bus.redirect) begin
               state_d = StFetch;
               pc_d    = redirAligned;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      bus.mem_addr   = pc_q;
      bus.mem_read   = (state_q == StFetch) || (state_q == StWait);
      bus.mem_write  = 1'b0;
      bus.mem_wdata  = 32'd0;
      bus.inst_valid = (state_q == StHold);
      bus.inst       = inst_q;
      bus.inst_pc    = instPc_q;
      bus.inst_fmt   = fmt_q;
      halted         = (state_q == StHalt);
      fetch_count    = count_q;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: dutA (default parameters) takes directed then random traffic; dutB
// (wrapping start PC, 3-cycle memory, MAX_FETCH=11, no JAL follow, halt on illegal) runs bounded programs.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstA_n, startA, haltedA;
   logic [31:0] countA;
   logic        rstB_n, startB, haltedB;
   logic [31:0] countB;

   fetch_sequencer_if busA ();
   fetch_sequencer_if busB ();

   fetch_sequencer dutA (
      .clk         (clk),
      .rst_n       (rstA_n),
      .start       (startA),
      .bus         (busA.master),
      .halted      (haltedA),
      .fetch_count (countA)
   );

   fetch_sequencer #(
      .RESET_PC        (32'hFFFF_FFFC),
      .MEM_LAT         (3),
      .MAX_FETCH       (32'd11),
      .FOLLOW_JAL      (1'b0),
      .HALT_ON_ILLEGAL (1'b1)
   ) dutB (
      .clk         (clk),
      .rst_n       (rstB_n),
      .start       (startB),
      .bus         (busB.master),
      .halted      (haltedB),
      .fetch_count (countB)
   );

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] memA [0:1023];
   bit          illegalB;

   logic [31:0] expQA [$];
   logic [31:0] expQB [$];
   int          expCountA, expCountB, handshakesA;
   bit          monAEn;
   logic [31:0] ePcA, ePcB;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   function automatic logic [31:0] memAWord(input logic [31:0] addr);
      return memA[addr[11:2]];
   endfunction

   function automatic logic [31:0] memBWord(input logic [31:0] addr);
      if (illegalB && addr == 32'h8) return 32'hFFFF_FFFF;
      if (addr == 32'h0) return 32'h0080_006F;
      return 32'h0000_0013;
   endfunction

   function automatic logic [31:0] expectFmt(input logic [31:0] word);
      case (word[6:0])
         7'h33:        return 32'd1;
         7'h03, 7'h13: return 32'd2;
         7'h23:        return 32'd3;
         7'h63:        return 32'd4;
         7'h6F:        return 32'd5;
         default:      return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] alignPc(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   // Where the program goes after the word at pc: jump target for JAL when followed, else next word.
   function automatic logic [31:0] nextPc(input logic [31:0] pc, input logic [31:0] word, input bit followJal);
      logic [20:0] off;
      off = {word[31], word[19:12], word[20], word[30:21], 1'b0};
      if (followJal && word[6:0] == 7'h6F) return alignPc(pc + {{11{off[20]}}, off});
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] randomWord();
      logic [31:0] w;
      logic [6:0]  op;
      w = $urandom;
      case ($urandom_range(0, 7))
         0:       op = 7'h33;
         1:       op = 7'h03;
         2:       op = 7'h13;
         3:       op = 7'h23;
         4:       op = 7'h63;
         5:       op = 7'h6F;
         6:       op = w[6:0] ^ 7'h55;
         default: op = 7'h13;
      endcase
      return {w[31:7], op};
   endfunction

   always @(posedge clk) if (busA.mem_read) busA.mem_rdata <= memAWord(busA.mem_addr);
   always @(posedge clk) if (busB.mem_read) busB.mem_rdata <= memBWord(busB.mem_addr);

   always @(negedge clk) begin
      if (monAEn && rstA_n) begin
         if (busA.inst_valid) begin
            if (expQA.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL A unexpected instruction: got pc 0x%08h, expected none", busA.inst_pc);
            end else begin
               ePcA = expQA[0];
               checkOutput("A inst_pc", busA.inst_pc, ePcA);
               checkOutput("A inst", busA.inst, memAWord(ePcA));
               checkOutput("A inst_fmt", 32'(busA.inst_fmt), expectFmt(memAWord(ePcA)));
               checkOutput("A mem_read while holding", 32'(busA.mem_read), 32'd0);
               if (busA.inst_ready) begin
                  checkOutput("A fetch_count at handshake", countA, 32'(expCountA));
                  expCountA++;
                  handshakesA++;
                  void'(expQA.pop_front());
                  expQA.push_back(busA.redirect ? alignPc(busA.redirect_pc)
                                                : nextPc(ePcA, memAWord(ePcA), 1'b1));
               end else if (busA.redirect) begin
                  void'(expQA.pop_front());
                  expQA.push_back(alignPc(busA.redirect_pc));
               end
            end
         end else if (busA.redirect) begin
            expQA.delete();
            expQA.push_back(alignPc(busA.redirect_pc));
         end
      end
   end

   always @(negedge clk) begin
      if (rstB_n && busB.inst_valid && busB.inst_ready) begin
         if (expQB.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL B unexpected handshake: got pc 0x%08h, expected none", busB.inst_pc);
         end else begin
            ePcB = expQB.pop_front();
            checkOutput("B inst_pc", busB.inst_pc, ePcB);
            checkOutput("B inst", busB.inst, memBWord(ePcB));
            checkOutput("B inst_fmt", 32'(busB.inst_fmt), expectFmt(memBWord(ePcB)));
            checkOutput("B fetch_count at handshake", countB, 32'(expCountB));
            expCountB++;
         end
      end
   end

   task automatic waitValidA(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = busA.inst_valid;
      end
      checkCount++;
      if (seen) passCount++;
      else $display("[TB] FAIL %s: inst_valid stayed 0, expected 1 within 20 cycles", name);
   endtask

   task automatic checkResetA(input string tag);
      checkOutput({tag, " mem_addr"}, busA.mem_addr, 32'h28);
      checkOutput({tag, " mem_read"}, 32'(busA.mem_read), 32'd0);
      checkOutput({tag, " mem_write"}, 32'(busA.mem_write), 32'd0);
      checkOutput({tag, " inst_valid"}, 32'(busA.inst_valid), 32'd0);
      checkOutput({tag, " inst"}, busA.inst, 32'd0);
      checkOutput({tag, " inst_pc"}, busA.inst_pc, 32'd0);
      checkOutput({tag, " inst_fmt"}, 32'(busA.inst_fmt), 32'd0);
      checkOutput({tag, " halted"}, 32'(haltedA), 32'd0);
      checkOutput({tag, " fetch_count"}, countA, 32'd0);
   endtask

   task automatic applyStimulus(input int cycles);
      int startHs;
      @(posedge clk); #1;
      startA = 1'b1;
      expQA.push_back(32'h28);
      monAEn = 1'b1;
      @(posedge clk); #1;
      startA  = 1'b0;
      startHs = handshakesA;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         busA.inst_ready  = ($urandom_range(0, 3) != 0);
         busA.redirect    = ($urandom_range(0, 29) == 0);
         busA.redirect_pc = $urandom;
      end
      busA.redirect = 1'b0;
      checkOutput("A random-phase progress (>=100 handshakes)", 32'(handshakesA - startHs >= 100), 32'd1);
   endtask

   task automatic runB(input bit illegal, input int nExp);
      logic [31:0] pc;
      int lat;
      illegalB = illegal;
      rstB_n   = 1'b0;
      expQB.delete();
      expCountB = 0;
      @(posedge clk); #1;
      checkOutput("B reset mem_addr", busB.mem_addr, 32'hFFFF_FFFC);
      checkOutput("B reset halted", 32'(haltedB), 32'd0);
      checkOutput("B reset fetch_count", countB, 32'd0);
      rstB_n = 1'b1;
      pc = 32'hFFFF_FFFC;
      for (int i = 0; i < nExp; i++) begin
         expQB.push_back(pc);
         pc = pc + 32'd4;
      end
      @(posedge clk); #1;
      startB = 1'b1;
      @(posedge clk); #1;
      startB = 1'b0;
      lat = 0;
      while (lat < 20 && !busB.inst_valid) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("B start-to-valid latency", 32'(lat), 32'd4);
      for (int c = 0; c < 300 && expQB.size() != 0; c++) begin
         @(posedge clk); #1;
         busB.inst_ready = ($urandom_range(0, 1) != 0);
      end
      checkOutput("B outstanding expected instructions", 32'(expQB.size()), 32'd0);
      busB.inst_ready = 1'b1;
      checkOutput("B halted", 32'(haltedB), 32'd1);
      checkOutput("B mem_read when halted", 32'(busB.mem_read), 32'd0);
      checkOutput("B fetch_count when halted", countB, 32'(nExp));
      startB           = 1'b1;
      busB.redirect    = 1'b1;
      busB.redirect_pc = 32'h40;
      repeat (3) @(posedge clk);
      #1;
      startB        = 1'b0;
      busB.redirect = 1'b0;
      checkOutput("B halted after start/redirect", 32'(haltedB), 32'd1);
      checkOutput("B mem_read after start/redirect", 32'(busB.mem_read), 32'd0);
      checkOutput("B inst_valid after start/redirect", 32'(busB.inst_valid), 32'd0);
      checkOutput("B fetch_count after start/redirect", countB, 32'(nExp));
   endtask

   initial begin
      rstA_n = 1'b0; rstB_n = 1'b0; startA = 1'b0; startB = 1'b0;
      busA.inst_ready = 1'b0; busA.redirect = 1'b0; busA.redirect_pc = 32'd0;
      busB.inst_ready = 1'b0; busB.redirect = 1'b0; busB.redirect_pc = 32'd0;
      monAEn = 1'b0; illegalB = 1'b0; expCountA = 0; expCountB = 0; handshakesA = 0;
      for (int i = 0; i < 1024; i++) memA[i] = randomWord();
      memA[10] = 32'h00A0_0293;
      memA[11] = 32'h0080_006F;
      memA[12] = 32'h0000_0013;
      memA[13] = 32'h0053_03B3;

      repeat (3) @(posedge clk);
      #1;
      checkResetA("A reset");
      @(negedge clk) rstA_n = 1'b1;

      @(posedge clk); #1;
      startA = 1'b1;
      busA.inst_ready = 1'b1;
      expQA.push_back(32'h28);
      monAEn = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      checkOutput("A first fetch mem_addr", busA.mem_addr, 32'h28);
      checkOutput("A first fetch mem_read", 32'(busA.mem_read), 32'd1);
      @(posedge clk); #1;
      checkOutput("A inst_valid one cycle after fetch", 32'(busA.inst_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("A inst_valid two cycles after start", 32'(busA.inst_valid), 32'd1);
      checkOutput("A first inst", busA.inst, 32'h00A0_0293);

      waitValidA("A jal at 0x2C");
      checkOutput("A jal inst_pc", busA.inst_pc, 32'h2C);
      @(posedge clk); #1;
      busA.inst_ready = 1'b0;
      checkOutput("A fetch after jal mem_addr", busA.mem_addr, 32'h34);
      waitValidA("A R-type at 0x34");
      repeat (5) begin
         @(negedge clk);
         checkOutput("A stalled inst", busA.inst, 32'h0053_03B3);
         checkOutput("A stalled inst_pc", busA.inst_pc, 32'h34);
         checkOutput("A stalled fetch_count", countA, 32'd2);
      end
      busA.inst_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("A fetch_count after stall", countA, 32'd3);
      checkOutput("A fetch after stall mem_addr", busA.mem_addr, 32'h38);

      @(posedge clk); #1;
      busA.redirect    = 1'b1;
      busA.redirect_pc = 32'h103;
      @(posedge clk); #1;
      busA.redirect = 1'b0;
      checkOutput("A redirect-in-wait mem_addr", busA.mem_addr, 32'h100);
      checkOutput("A redirect-in-wait inst_valid", 32'(busA.inst_valid), 32'd0);
      waitValidA("A word at 0x100");
      busA.redirect    = 1'b1;
      busA.redirect_pc = 32'h200;
      @(posedge clk); #1;
      busA.redirect = 1'b0;
      checkOutput("A redirect+handshake fetch_count", countA, 32'd4);
      checkOutput("A redirect+handshake mem_addr", busA.mem_addr, 32'h200);
      checkOutput("A redirect+handshake mem_read", 32'(busA.mem_read), 32'd1);

      @(posedge clk); #1;
      monAEn = 1'b0;
      rstA_n = 1'b0;
      #1;
      checkResetA("A mid-wait reset");
      @(negedge clk) rstA_n = 1'b1;
      expQA.delete();
      expCountA = 0;

      applyStimulus(1500);

      runB(1'b0, 11);
      runB(1'b1, 4);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
